// File: rtl/slew_limiter.sv
// Dual-channel slew-rate limiter. On each sample_clk rising edge, both channels step toward
// their targets through one shared add/compare datapath. Each channel also drives a "still slewing" gate.
module slew_limiter #(
    parameter int W          = 16,
    parameter int RATE_SHIFT = 8,
    parameter int GATE_HI    = 20000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_clk,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    output logic signed [W-1:0] sample_out0,
    output logic signed [W-1:0] sample_out1,
    output logic signed [W-1:0] sample_out2,
    output logic signed [W-1:0] sample_out3
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CALC_A,
        CALC_B,
        COMMIT
    } state_t;

    state_t state_q, state_d;

    logic                scHist_q;
    logic signed [W-1:0] targetA_q, rateA_q, targetB_q, rateB_q;
    logic signed [W-1:0] yA_q, yB_q;
    logic                gateA_q, gateB_q;
    logic signed [W-1:0] out0_q, out1_q, out2_q, out3_q;

    logic signed [W-1:0] selTarget, selY, selRate;
    logic        [W-1:0] stepRaw, step;
    logic signed [W:0]   targetExt, yExt, stepExt, moved, yNextExt;
    logic                goUp, overshoot;
    logic signed [W-1:0] yNext;
    logic                gateNext;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_clk && !scHist_q) state_d = LATCH;
            LATCH:   state_d = CALC_A;
            CALC_A:  state_d = CALC_B;
            CALC_B:  state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shared datapath: one adder and one comparator, steered to channel B only in CALC_B.
    // Working in W+1 bits keeps y +/- step from wrapping before the clamp to the target.
    always_comb begin
        selTarget = (state_q == CALC_B) ? targetB_q : targetA_q;
        selY      = (state_q == CALC_B) ? yB_q      : yA_q;
        selRate   = (state_q == CALC_B) ? rateB_q   : rateA_q;

        stepRaw   = (selRate > 0) ? (selRate >>> RATE_SHIFT) : '0;
        step      = (stepRaw == '0) ? {{(W-1){1'b0}}, 1'b1} : stepRaw;

        targetExt = {selTarget[W-1], selTarget};
        yExt      = {selY[W-1], selY};
        stepExt   = {1'b0, step};

        goUp      = targetExt > yExt;
        moved     = goUp ? (yExt + stepExt) : (yExt - stepExt);
        overshoot = goUp ? (moved > targetExt) : (moved < targetExt);
        yNextExt  = ((targetExt == yExt) || overshoot) ? targetExt : moved;

        yNext     = yNextExt[W-1:0];
        gateNext  = (yNextExt != targetExt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            scHist_q  <= 1'b0;
            targetA_q <= '0;
            rateA_q   <= '0;
            targetB_q <= '0;
            rateB_q   <= '0;
            yA_q      <= '0;
            yB_q      <= '0;
            gateA_q   <= 1'b0;
            gateB_q   <= 1'b0;
            out0_q    <= '0;
            out1_q    <= '0;
            out2_q    <= '0;
            out3_q    <= '0;
        end else begin
            state_q  <= state_d;
            scHist_q <= sample_clk;
            case (state_q)
                LATCH: begin
                    targetA_q <= sample_in0;
                    rateA_q   <= sample_in1;
                    targetB_q <= sample_in2;
                    rateB_q   <= sample_in3;
                end
                CALC_A: begin
                    yA_q    <= yNext;
                    gateA_q <= gateNext;
                end
                CALC_B: begin
                    yB_q    <= yNext;
                    gateB_q <= gateNext;
                end
                COMMIT: begin
                    out0_q <= yA_q;
                    out1_q <= yB_q;
                    out2_q <= gateA_q ? W'(GATE_HI) : '0;
                    out3_q <= gateB_q ? W'(GATE_HI) : '0;
                end
                default: ;
            endcase
        end
    end

    assign sample_out0 = out0_q;
    assign sample_out1 = out1_q;
    assign sample_out2 = out2_q;
    assign sample_out3 = out3_q;

endmodule

// File: doc/slew_limiter.md
Name: slew_limiter

Overview:
- Dual-channel slew-rate limiter core. Sits between the calibration stage's calibrated inputs and its calibrated outputs, in the same slot as the other selectable DSP cores.
- Each output channel tracks its target input. Per sample, it moves by at most a step size set by a companion rate-CV input.
- Two further outputs carry "still slewing" gates.
- Processing is time-multiplexed through one shared add/compare datapath, triggered on each sample_clk rising edge.

Parameters:
- W, 16, sample width in bits (signed two's complement).
- RATE_SHIFT, 8, right-shift applied to the rate CV to derive the step size.
- GATE_HI, 20000, value driven on a gate output while its channel is slewing.

Ports:
- clk  input  1  system clock (12 MHz domain).
- rst_n  input  1  asynchronous active-low reset.
- sample_clk  input  1  CODEC sample clock, synchronous to clk; its rising edge starts processing.
- sample_in0  input  W  channel A target signal (signed).
- sample_in1  input  W  channel A rate CV (signed).
- sample_in2  input  W  channel B target signal (signed).
- sample_in3  input  W  channel B rate CV (signed).
- sample_out0  output  W  channel A slewed output.
- sample_out1  output  W  channel B slewed output.
- sample_out2  output  W  channel A slewing gate (GATE_HI or 0).
- sample_out3  output  W  channel B slewing gate (GATE_HI or 0).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0.
  - Internal states yA and yB cleared to 0.
  - Latched inputs cleared.
  - sample_clk history register cleared to 0.
  - FSM returns to IDLE.
  - Reset asserted mid-sequence aborts the sequence; no partial output update occurs.
- Edge detect:
  - sc_d is a registered copy of sample_clk.
  - An edge is sample_clk=1 while sc_d=0, evaluated in IDLE only.
- FSM states: IDLE -> LATCH -> CALC_A -> CALC_B -> COMMIT -> IDLE. Every state except IDLE lasts exactly one clk.
  - LATCH: register all four sample_in values.
  - CALC_A: compute the next yA through the shared datapath.
  - CALC_B: compute the next yB through the shared datapath.
  - COMMIT: load sample_out0..3 from yA, yB and the two gate flags.
- Latency: outputs change on the 4th clk edge after the edge-detect cycle. Outputs are stable otherwise.
- An edge arriving while not in IDLE is ignored; it is not queued.
- Step size:
  - step = rate >> RATE_SHIFT when rate > 0, else 0.
  - step is then clamped to a minimum of 1, so a negative or small rate gives the slowest slew (step 1).
- Update rule:
  - All arithmetic is done in W+1 bits with sign-extended operands, so no intermediate wraps.
  - If t > y: y' = min(y + step, t).
  - If t < y: y' = max(y - step, t).
  - If t == y: y' = y.
  - y' always lies in the W-bit range because it is bounded by t; truncate to W bits.
- Gate: set to GATE_HI when y' != t after the update, else 0.
- Outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset check: hold rst_n low with inputs at 1234 -> all outputs 0. Release reset with no sample_clk edge -> outputs remain 0.
- Rise ramp: sample_in0=1000, sample_in1=25600 (step 100), starting from yA=0.
  - Each sample edge steps out0 by 100: 100, 200, ... 1000.
  - out2=20000 for the first 9 samples, then 0 from the 10th.
  - Each update lands exactly 4 clk after its edge detect.
- Fall with minimum step: yA settled at 10, then sample_in0=0, sample_in1=-5.
  - out0 steps 9, 8, ... 0, one per sample.
  - out2 stays 20000 until out0 reaches 0.
- Extreme swing: yB settled at 32767, then sample_in2=-32768, sample_in3=32767 (step 127).
  - out1 goes 32640, 32513, ... with no wrap.
  - The final step clamps exactly to -32768.
  - Channel A is unaffected throughout.
- Busy-edge and mid-operation reset:
  - A second sample_clk rising edge during CALC_A -> ignored; exactly one update.
  - rst_n pulsed low during CALC_B -> outputs 0 and the FSM in IDLE; the next edge processes normally from y=0.
